psimd_addsat: RTL and testbench

Parametrised, pipelined packed-SIMD saturating adder/subtractor. It is the next-generation replacement for the fixed 4x4-bit signed saturating packed add. It adds configurable lane width and lane count, subtract mode, unsigned saturation, valid/ready flow control, and per-lane saturation status. It sits in the execute stage as a multi-cycle functional unit beside the ALU.

---
 rtl/psimd_pkg.sv | 27 ++
 rtl/psimd_lane_sat.sv | 40 ++++
 rtl/psimd_addsat.sv | 117 +++++++++++
 tb/tb_psimd_addsat.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psimd_pkg.sv
// Shared definitions for the packed-SIMD saturating adder: lane saturation bounds
// computed at a fixed wide width so any lane width up to MAX_LANE_W can compare against them.
package psimd_pkg;

    localparam int MAX_LANE_W = 64;

    typedef logic signed [MAX_LANE_W:0] bound_t;

    function automatic bound_t sat_max_s(input int lane_w);
        bound_t one;
        one = bound_t'(1);
        return (one <<< (lane_w - 1)) - one;
    endfunction

    function automatic bound_t sat_min_s(input int lane_w);
        bound_t one;
        one = bound_t'(1);
        return -(one <<< (lane_w - 1));
    endfunction

    function automatic bound_t sat_max_u(input int lane_w);
        bound_t one;
        one = bound_t'(1);
        return (one <<< lane_w) - one;
    endfunction

endpackage

// File: rtl/psimd_lane_sat.sv
// Combinational clamp of one lane: takes the (LANE_W+1)-bit raw result and the
// mode bits, produces the saturated lane value and whether it was clamped.
module psimd_lane_sat
    import psimd_pkg::*;
#(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W:0]   raw,
    input  logic              is_sub,
    input  logic              is_unsigned,
    output logic [LANE_W-1:0] res,
    output logic              sat
);

    bound_t raw_s;
    bound_t raw_u;

    always_comb begin
        raw_s = bound_t'($signed(raw));
        raw_u = bound_t'(raw);
        res   = raw[LANE_W-1:0];
        sat   = 1'b0;
        if (is_unsigned) begin
            // A set top bit is a carry on add and a borrow on sub; both exceed max_u.
            if (raw_u > sat_max_u(LANE_W)) begin
                sat = 1'b1;
                res = is_sub ? '0 : '1;
            end
        end else begin
            if (raw_s > sat_max_s(LANE_W)) begin
                sat = 1'b1;
                res = {1'b0, {(LANE_W-1){1'b1}}};
            end else if (raw_s < sat_min_s(LANE_W)) begin
                sat = 1'b1;
                res = {1'b1, {(LANE_W-1){1'b0}}};
            end
        end
    end

endmodule

// File: rtl/psimd_addsat.sv
// Two-stage packed-SIMD saturating add/sub with valid/ready flow control:
// S1 holds per-lane raw results, S2 holds the clamped vector and drives the outputs.
module psimd_addsat
    import psimd_pkg::*;
#(
    parameter  int LANE_W = 4,
    parameter  int LANES  = 4,
    localparam int W      = LANE_W * LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             op_sub,
    input  logic             op_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     sum,
    output logic [LANES-1:0] sat_lane,
    output logic [LANES-1:0] sat_sticky,
    input  logic             sticky_clr
);

    logic                          s1_valid;
    logic [LANES-1:0][LANE_W:0]    s1_raw;
    logic                          s1_sub;
    logic                          s1_uns;
    logic                          s2_valid;
    logic [W-1:0]                  s2_sum;
    logic [LANES-1:0]              s2_sat;
    logic [LANES-1:0]              sticky;

    logic                          s2_adv;
    logic                          s1_adv;
    logic                          in_fire;
    logic                          out_fire;
    logic [LANES-1:0][LANE_W:0]    raw_next;
    logic [LANES-1:0][LANE_W-1:0]  lane_res;
    logic [LANES-1:0]              lane_sat;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;

    // Extend each lane by one bit so the raw sum/difference can never wrap.
    always_comb begin
        logic [LANE_W:0] ea;
        logic [LANE_W:0] eb;
        ea       = '0;
        eb       = '0;
        raw_next = '0;
        for (int i = 0; i < LANES; i++) begin
            ea = {(op_unsigned ? 1'b0 : a[i*LANE_W+LANE_W-1]), a[i*LANE_W +: LANE_W]};
            eb = {(op_unsigned ? 1'b0 : b[i*LANE_W+LANE_W-1]), b[i*LANE_W +: LANE_W]};
            raw_next[i] = op_sub ? (ea + ~eb + {{LANE_W{1'b0}}, 1'b1}) : (ea + eb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_sub   <= 1'b0;
            s1_uns   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_raw <= raw_next;
                s1_sub <= op_sub;
                s1_uns <= op_unsigned;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psimd_lane_sat #(.LANE_W(LANE_W)) u_sat (
            .raw         (s1_raw[g]),
            .is_sub      (s1_sub),
            .is_unsigned (s1_uns),
            .res         (lane_res[g]),
            .sat         (lane_sat[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_sat   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_adv) begin
                s2_sum <= lane_res;
                s2_sat <= lane_sat;
            end
        end
    end

    // Clear and set in the same cycle: freshly saturated lanes win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky_clr ? '0 : sticky) | (out_fire ? s2_sat : '0);
        end
    end

    assign out_valid  = s2_valid;
    assign sum        = s2_sum;
    assign sat_lane   = s2_sat;
    assign sat_sticky = sticky;

endmodule

// File: tb/tb_psimd_addsat.sv
// Scoreboard bench for psimd_addsat: an integer reference model predicts each
// accepted vector, results are popped and compared as the unit hands them out.
module tb_psimd_addsat;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        uns;
    } stim_t;

    typedef struct packed {
        logic [15:0] sum;
        logic [3:0]  sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, op_sub, op_unsigned;
    logic        out_valid, out_ready, sticky_clr;
    logic [15:0] a, b, sum;
    logic [3:0]  sat_lane, sat_sticky;

    logic        in_valid8, in_ready8, out_valid8;
    logic        out_ready8, sticky_clr8, sub8, uns8;
    logic [15:0] a8, b8, sum8;
    logic [1:0]  sat_lane8, sat_sticky8;

    stim_t       stim_q[$];
    exp_t        exp_q[$];
    logic [3:0]  sticky_m;
    int          total = 0;
    int          bad = 0;
    int          n_out;

    always #5 clk = ~clk;

    psimd_addsat #(.LANE_W(4), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .op_unsigned(op_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .sat_lane(sat_lane), .sat_sticky(sat_sticky), .sticky_clr(sticky_clr)
    );

    psimd_addsat #(.LANE_W(8), .LANES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op_sub(sub8), .op_unsigned(uns8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
        .sat_lane(sat_lane8), .sat_sticky(sat_sticky8), .sticky_clr(sticky_clr8)
    );

    function automatic exp_t model(input int lw, input int ln, input stim_t s);
        exp_t e;
        e = '0;
        for (int i = 0; i < ln; i++) begin
            int va, vb, r, mx, mn, res;
            va = 0;
            vb = 0;
            for (int j = 0; j < lw; j++) begin
                va += int'(s.a[i*lw+j]) << j;
                vb += int'(s.b[i*lw+j]) << j;
            end
            if (!s.uns) begin
                if (va >= (1 << (lw - 1))) va -= (1 << lw);
                if (vb >= (1 << (lw - 1))) vb -= (1 << lw);
                mx = (1 << (lw - 1)) - 1;
                mn = -(1 << (lw - 1));
            end else begin
                mx = (1 << lw) - 1;
                mn = 0;
            end
            r = s.sub ? va - vb : va + vb;
            res = r;
            if (r > mx) begin
                res = mx;
                e.sat[i] = 1'b1;
            end else if (r < mn) begin
                res = mn;
                e.sat[i] = 1'b1;
            end
            for (int j = 0; j < lw; j++) e.sum[i*lw+j] = res[j];
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of scoreboard-driven traffic; inputs change and outputs are sampled mid-cycle.
    task automatic runCycle(input logic ordy, input logic clr);
        logic accepted, xfer;
        @(negedge clk);
        out_ready  = ordy;
        sticky_clr = clr;
        if (stim_q.size() > 0) begin
            in_valid    = 1'b1;
            a           = stim_q[0].a;
            b           = stim_q[0].b;
            op_sub      = stim_q[0].sub;
            op_unsigned = stim_q[0].uns;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        checkOutput("sticky", sat_sticky, sticky_m);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out", out_valid, 0);
            end else begin
                checkOutput("sb_sum", sum, exp_q[0].sum);
                checkOutput("sb_sat", sat_lane, exp_q[0].sat);
            end
        end
        if (exp_q.size() == 2) begin
            checkOutput("full_out_valid", out_valid, 1);
            if (!ordy) checkOutput("full_in_ready", in_ready, 0);
        end
        accepted = in_valid && in_ready;
        xfer     = out_valid && out_ready;
        sticky_m = clr ? 4'b0 : sticky_m;
        if (xfer && exp_q.size() > 0) begin
            sticky_m |= exp_q[0].sat;
            void'(exp_q.pop_front());
            n_out++;
        end
        if (accepted) begin
            exp_q.push_back(model(4, 4, stim_q[0]));
            void'(stim_q.pop_front());
        end
        @(posedge clk);
    endtask

    // Single vector into an empty pipe: checks the two-cycle latency and the literal result.
    task automatic applyStimulus(input stim_t s, input logic [15:0] exp_sum,
                                 input logic [3:0] exp_sat, input logic clr_on_xfer);
        @(negedge clk);
        in_valid    = 1'b1;
        a           = s.a;
        b           = s.b;
        op_sub      = s.sub;
        op_unsigned = s.uns;
        out_ready   = 1'b1;
        sticky_clr  = 1'b0;
        #1 checkOutput("dir_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 checkOutput("dir_lat1_valid", out_valid, 0);
        @(negedge clk);
        sticky_clr = clr_on_xfer;
        #1;
        checkOutput("dir_lat2_valid", out_valid, 1);
        checkOutput("dir_sum", sum, exp_sum);
        checkOutput("dir_sat", sat_lane, exp_sat);
        sticky_m = (clr_on_xfer ? 4'b0 : sticky_m) | exp_sat;
        @(negedge clk);
        sticky_clr = 1'b0;
    endtask

    initial begin
        stim_t s;
        exp_t  e8;
        int    cyc;
        int    w8;
        in_valid = 0; a = 0; b = 0; op_sub = 0; op_unsigned = 0;
        out_ready = 1; sticky_clr = 0; sticky_m = 0; n_out = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; sub8 = 0; uns8 = 0;
        out_ready8 = 1; sticky_clr8 = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_sat", sat_lane, 0);
        checkOutput("rst_sticky", sat_sticky, 0);
        rst_n = 1'b1;
        #1 checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] directed vectors");
        applyStimulus('{a:16'h783F, b:16'h1F21, sub:1'b0, uns:1'b0}, 16'h7850, 4'b1100, 1'b0);
        #1 checkOutput("sticky_case1", sat_sticky, 4'b1100);
        applyStimulus('{a:16'h0007, b:16'h0001, sub:1'b0, uns:1'b0}, 16'h0007, 4'b0001, 1'b1);
        #1 checkOutput("sticky_clr_set", sat_sticky, 4'b0001);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        sticky_m   = 4'b0;
        #1 checkOutput("sticky_clr_only", sat_sticky, 4'b0000);
        applyStimulus('{a:16'hF0A8, b:16'h2019, sub:1'b0, uns:1'b1}, 16'hF0BF, 4'b1001, 1'b0);
        applyStimulus('{a:16'h8070, b:16'h1090, sub:1'b1, uns:1'b0}, 16'h8070, 4'b1010, 1'b0);
        applyStimulus('{a:16'h1234, b:16'h2222, sub:1'b1, uns:1'b1}, 16'h0012, 4'b1000, 1'b0);

        $display("[TB] stream with mid-stream stall");
        for (int i = 0; i < 6; i++) begin
            s.a   = 16'($urandom);
            s.b   = 16'($urandom);
            s.sub = 1'($urandom);
            s.uns = 1'($urandom);
            stim_q.push_back(s);
        end
        n_out = 0;
        cyc   = 0;
        while (cyc < 80 && (stim_q.size() > 0 || exp_q.size() > 0)) begin
            runCycle(!(cyc >= 3 && cyc < 8), 1'b0);
            cyc++;
        end
        checkOutput("stream_drained", stim_q.size() + exp_q.size(), 0);
        checkOutput("stream_count", n_out, 6);
        applyStimulus('{a:16'h4444, b:16'h4444, sub:1'b0, uns:1'b0}, 16'h7777, 4'b1111, 1'b0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 4; i++) begin
            s.a   = 16'($urandom);
            s.b   = 16'($urandom);
            s.sub = 1'b0;
            s.uns = 1'b1;
            stim_q.push_back(s);
        end
        repeat (3) runCycle(1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_sum", sum, 0);
        checkOutput("midrst_sat", sat_lane, 0);
        checkOutput("midrst_sticky", sat_sticky, 0);
        in_valid = 1'b0;
        stim_q.delete();
        exp_q.delete();
        sticky_m = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            runCycle(1'b1, 1'b0);
            #1 checkOutput("post_rst_idle", out_valid, 0);
        end

        $display("[TB] 8-bit x 2 lane instance");
        s  = '{a:16'h7F80, b:16'h01FF, sub:1'b0, uns:1'b0};
        e8 = model(8, 2, s);
        @(negedge clk);
        in_valid8 = 1'b1;
        a8 = s.a;
        b8 = s.b;
        #1 checkOutput("w8_in_ready", in_ready8, 1);
        @(negedge clk);
        in_valid8 = 1'b0;
        w8 = 0;
        while (!out_valid8 && w8 < 10) begin
            @(negedge clk);
            w8++;
        end
        #1;
        checkOutput("w8_valid", out_valid8, 1);
        checkOutput("w8_latency", w8, 1);
        checkOutput("w8_sum", sum8, e8.sum);
        checkOutput("w8_sat", sat_lane8, e8.sat[1:0]);
        checkOutput("w8_sum_lit", sum8, 16'h7F80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
